rd_burst_dma: RTL and testbench
===============================

// Module: rd_burst_dma
// PURPOSE
// Parametrised Avalon-MM burst read master. It copies the byte region [pkt_begin, pkt_end) from HPS/SDRAM into the capture FIFO.
// Bursts are split by MAX_BURST and BOUNDARY_BYTES, the address advances per burst, and issue is credit-gated on FIFO free space.
// A one-cycle done pulse is returned to the control register block.
// PARAMETERS
// ADDR_W          32    Avalon address width (byte address)
// DATA_W          32    readdata/fifo_in width; power of 2, >= 8; BPW = DATA_W/8 bytes per word
// MAX_BURST       16    max beats per burst; power of 2, >= 1
// BURST_W         16    burstcount width; must satisfy 2**(BURST_W-1) >= MAX_BURST
// FIFO_CNT_W      10    width of fifo_free
// BOUNDARY_BYTES  4096  bursts never cross a multiple of this; power of 2, >= MAX_BURST*BPW
// PORTS
// clk            in   1           clock
// reset          in   1           synchronous, active-low reset
// start          in   1           pulse: begin transfer (sampled in IDLE only)
// pkt_begin      in   ADDR_W      first byte address (BPW-aligned)
// pkt_end        in   ADDR_W      one past last byte (BPW-aligned)
// fifo_free      in   FIFO_CNT_W  free words in downstream FIFO
// fifo_in        out  DATA_W      data word to FIFO
// wr_to_fifo     out  1           FIFO write strobe
// busy           out  1           high outside IDLE
// done           out  1           one-cycle completion pulse
// error          out  1           one-cycle pulse with done: bad region
// address        out  ADDR_W      Avalon burst start address
// read           out  1           Avalon read request
// burstcount     out  BURST_W     Avalon burst length in beats
// readdata       in   DATA_W      Avalon read data
// readdatavalid  in   1           Avalon data beat valid
// waitrequest    in   1           Avalon command stall
// BEHAVIOUR
// - Reset (reset==0 at posedge): state=IDLE. fifo_in, wr_to_fifo, busy, done, error, address and read all 0. burstcount=1.
//   Reset mid-transfer abandons the transfer immediately; no done pulse is issued.
// - FSM: IDLE -> CHECK on start. CHECK -> DONE if pkt_end<=pkt_begin or either address has low log2(BPW) bits !=0 (error=1).
//   Otherwise CHECK -> ISSUE. ISSUE -> DRAIN when words_left==0 after a command is accepted. DRAIN -> DONE when outstanding==0.
//   DONE -> IDLE after exactly one cycle; done=1 in that cycle.
// - In CHECK: pkt_begin/pkt_end are registered. words_left = (pkt_end-pkt_begin)>>log2(BPW), ADDR_W wide. cur_addr=pkt_begin.
// - Burst length: blen = min(MAX_BURST, words_left, (BOUNDARY_BYTES - cur_addr%BOUNDARY_BYTES)/BPW).
// - Issue rule: read is asserted in ISSUE only if fifo_free >= outstanding + blen.
//   Once asserted, read, address and burstcount are held stable until a cycle with waitrequest==0 (command accepted).
// - On acceptance: cur_addr += blen*BPW; words_left -= blen; outstanding += blen. read drops for at least one cycle before the next burst.
// - outstanding (BURST_W+1 bits): +blen on acceptance, -1 per readdatavalid. Both in the same cycle: net += blen-1.
// - Data path: each readdatavalid beat in ISSUE/DRAIN gives wr_to_fifo=1 and fifo_in=readdata on the next cycle (latency 1).
//   Beats arriving in IDLE/CHECK/DONE are dropped. fifo_in holds its value when not writing.
// - start while busy is ignored. start in the DONE cycle is ignored.
// - Address wrap: cur_addr is modulo 2**ADDR_W. A region crossing the top of memory is a caller error and is not detected.
// - fifo_free < blen with outstanding==0: ISSUE stalls indefinitely (no deadlock recovery).
// CONFIGURATION
// - RD_BURST_DMA_STATS_EN defined: adds output stat_words [31:0] and output stat_stall_cycles [31:0].
//   stat_words counts beats written to the FIFO. stat_stall_cycles counts ISSUE cycles with read==1 && waitrequest==1
//   plus ISSUE cycles blocked by the credit rule. Both clear on reset and on start accepted in IDLE, and saturate at 2**32-1.
// - RD_BURST_DMA_STATS_EN undefined: neither port nor the counters exist. Behaviour is otherwise identical.
// TESTING
// - begin=0x1000, end=0x1100, BPW=4, fifo_free=512, no waitrequest -> 4 bursts of 16 at 0x1000/0x1040/0x1080/0x10C0;
//   64 FIFO writes in order; one done, error=0.
// - begin=0x0FF8, end=0x1008 -> burst of 2 at 0x0FF8, then burst of 2 at 0x1000 (4 KiB boundary split).
// - begin=0x2000, end=0x2014 -> single burst, burstcount=5; done 1 cycle after the 5th FIFO write.
// - begin=end=0x3000, then begin=0x3002 -> no read asserted; done=error=1 for 1 cycle each time.
// - waitrequest held 3 cycles on first burst -> address/burstcount/read stable for 4 cycles; stat_stall_cycles=3 with STATS_EN.
// - fifo_free=8, 64-word region -> no read until fifo_free>=16; then reset low mid-DRAIN -> all outputs 0 next cycle,
//   no done, late readdatavalid ignored.

Source files
------------

// File: rtl/rd_burst_dma.sv
// rd_burst_dma: Avalon-MM burst read master that copies the byte region
// [pkt_begin, pkt_end) into a capture FIFO.
//
// Bursts are limited by MAX_BURST, by the words remaining and by the next
// BOUNDARY_BYTES boundary. A burst is only issued when the FIFO has room for
// every beat already in flight plus the new burst.
//
// Optional feature macro: RD_BURST_DMA_STATS_EN adds the stat_words and
// stat_stall_cycles counters and their output ports.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   start                 begin-transfer pulse, honoured in IDLE only
//   pkt_begin, pkt_end    byte region, both BPW-aligned
//   fifo_free             free words in the downstream FIFO
//   fifo_in, wr_to_fifo   FIFO write data and strobe
//   busy, done, error     status: busy outside IDLE, one-cycle done/error pulse
//   address, read,        Avalon burst read command
//   burstcount
//   readdata,             Avalon read response and command stall
//   readdatavalid,
//   waitrequest
//   stat_words,           (RD_BURST_DMA_STATS_EN only) beats written, stall cycles
//   stat_stall_cycles
//
// state | meaning
// IDLE  | waiting for start
// CHECK | validate region, load address and word count
// ISSUE | issue credit-gated bursts until all words are requested
// DRAIN | wait for every outstanding beat to return
// DONE  | one-cycle done (and error) pulse
module rd_burst_dma #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_BURST      = 16,
    parameter int BURST_W        = 16,
    parameter int FIFO_CNT_W     = 10,
    parameter int BOUNDARY_BYTES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     pkt_begin,
    input  logic [ADDR_W-1:0]     pkt_end,
    input  logic [FIFO_CNT_W-1:0] fifo_free,
    output logic [DATA_W-1:0]     fifo_in,
    output logic                  wr_to_fifo,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     address,
    output logic                  read,
    output logic [BURST_W-1:0]    burstcount,
    input  logic [DATA_W-1:0]     readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest
`ifdef RD_BURST_DMA_STATS_EN
    ,
    output logic [31:0]           stat_words,
    output logic [31:0]           stat_stall_cycles
`endif
);

    localparam int BPW    = DATA_W / 8;
    localparam int BPW_LG = $clog2(BPW);
    localparam int AW1    = ADDR_W + 1;
    localparam int OUT_W  = BURST_W + 1;
    localparam int CW     = ((FIFO_CNT_W > OUT_W) ? FIFO_CNT_W : OUT_W) + 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPW - 1);
    localparam logic [ADDR_W-1:0] BND_MASK   = ADDR_W'(BOUNDARY_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]    words_left_q, words_left_d;
    logic [OUT_W-1:0]     outstanding_q, outstanding_d;
    logic                 read_q, read_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BURST_W-1:0]   bcnt_q, bcnt_d;
    logic                 err_q, err_d;
    logic                 wr_q, wr_d;
    logic [DATA_W-1:0]    fifo_in_q, fifo_in_d;

    logic [ADDR_W-1:0]    bnd_off;
    logic [AW1-1:0]       bnd_words;
    logic [AW1-1:0]       blen_full;
    logic [BURST_W-1:0]   blen;
    logic                 credit_ok;
    logic                 accept;
    logic                 beat;
    logic                 bad_region;
    logic [ADDR_W-1:0]    words_next;

    // Burst length: smallest of the burst cap, the words left and the
    // distance (in words) to the next boundary.
    always_comb begin
        bnd_off   = cur_addr_q & BND_MASK;
        bnd_words = (AW1'(BOUNDARY_BYTES) - {1'b0, bnd_off}) >> BPW_LG;
        blen_full = AW1'(MAX_BURST);
        if ({1'b0, words_left_q} < blen_full) begin
            blen_full = {1'b0, words_left_q};
        end
        if (bnd_words < blen_full) begin
            blen_full = bnd_words;
        end
        blen = BURST_W'(blen_full);
    end

    assign credit_ok  = CW'(fifo_free) >= (CW'(outstanding_q) + CW'(blen));
    assign accept     = (state_q == S_ISSUE) && read_q && !waitrequest;
    assign beat       = readdatavalid && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    assign bad_region = (pkt_end <= pkt_begin) ||
                        ((pkt_begin & ALIGN_MASK) != '0) ||
                        ((pkt_end & ALIGN_MASK) != '0);
    assign words_next = words_left_q - ADDR_W'(bcnt_q);

    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        words_left_d = words_left_q;
        read_d       = read_q;
        addr_d       = addr_q;
        bcnt_d       = bcnt_q;
        err_d        = err_q;
        wr_d         = beat;
        fifo_in_d    = beat ? readdata : fifo_in_q;

        // In-flight beat count; a burst accepted in the same cycle as a
        // returning beat nets to +blen-1.
        outstanding_d = outstanding_q
                      + (accept ? OUT_W'(bcnt_q) : '0)
                      - (beat ? OUT_W'(1) : '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                err_d         = bad_region;
                cur_addr_d    = pkt_begin;
                words_left_d  = (pkt_end - pkt_begin) >> BPW_LG;
                outstanding_d = '0;
                state_d       = bad_region ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    read_d       = 1'b0;
                    cur_addr_d   = cur_addr_q + (ADDR_W'(bcnt_q) << BPW_LG);
                    words_left_d = words_next;
                    if (words_next == '0) begin
                        state_d = S_DRAIN;
                    end
                end else if (!read_q && (words_left_q != '0) && credit_ok) begin
                    // read_q was low this cycle, so a fresh command always
                    // follows at least one idle cycle.
                    read_d = 1'b1;
                    addr_d = cur_addr_q;
                    bcnt_d = blen;
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            cur_addr_q    <= '0;
            words_left_q  <= '0;
            outstanding_q <= '0;
            read_q        <= 1'b0;
            addr_q        <= '0;
            bcnt_q        <= BURST_W'(1);
            err_q         <= 1'b0;
            wr_q          <= 1'b0;
            fifo_in_q     <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            words_left_q  <= words_left_d;
            outstanding_q <= outstanding_d;
            read_q        <= read_d;
            addr_q        <= addr_d;
            bcnt_q        <= bcnt_d;
            err_q         <= err_d;
            wr_q          <= wr_d;
            fifo_in_q     <= fifo_in_d;
        end
    end

    assign fifo_in    = fifo_in_q;
    assign wr_to_fifo = wr_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_DONE) && err_q;
    assign address    = addr_q;
    assign read       = read_q;
    assign burstcount = bcnt_q;

`ifdef RD_BURST_DMA_STATS_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [31:0] stat_stall_q, stat_stall_d;
    logic        stall_cycle;

    // Stalled: command held off by waitrequest, or not issued for lack of credit.
    assign stall_cycle = (state_q == S_ISSUE) &&
                         ((read_q && waitrequest) ||
                          (!read_q && (words_left_q != '0) && !credit_ok));

    always_comb begin
        stat_words_d = stat_words_q;
        stat_stall_d = stat_stall_q;
        if ((state_q == S_IDLE) && start) begin
            stat_words_d = '0;
            stat_stall_d = '0;
        end else begin
            if (wr_q && (stat_words_q != '1)) begin
                stat_words_d = stat_words_q + 32'd1;
            end
            if (stall_cycle && (stat_stall_q != '1)) begin
                stat_stall_d = stat_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_words_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_words_q <= stat_words_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_words        = stat_words_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_rd_burst_dma.sv
// Self-checking bench for rd_burst_dma (default parameters, BPW = 4).
// An Avalon slave model returns mem(addr) for each accepted burst; expected
// commands are queued by the stimulus, expected FIFO words are queued when a
// command is accepted and compared as the DUT writes the FIFO.
module tb_rd_burst_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pkt_begin;
    logic [31:0] pkt_end;
    logic [9:0]  fifo_free;
    logic [31:0] fifo_in;
    logic        wr_to_fifo;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] address;
    logic        read;
    logic [15:0] burstcount;
    logic [31:0] readdata      = 32'h0;
    logic        readdatavalid = 1'b0;
    logic        waitrequest   = 1'b0;
`ifdef RD_BURST_DMA_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    rd_burst_dma dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pkt_begin     (pkt_begin),
        .pkt_end       (pkt_end),
        .fifo_free     (fifo_free),
        .fifo_in       (fifo_in),
        .wr_to_fifo    (wr_to_fifo),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .address       (address),
        .read          (read),
        .burstcount    (burstcount),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest)
`ifdef RD_BURST_DMA_STATS_EN
        ,
        .stat_words        (stat_words),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic [15:0] cnt;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] resp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    int wait_cnt    = 0;
    int accepts     = 0;
    int done_cnt    = 0;
    int err_cnt     = 0;
    int cyc         = 0;
    int last_wr_cyc = 0;
    int done_cyc    = 0;
    int hold_cnt    = 0;
    int first_hold  = 0;
    int o_model     = 0;
    int prev_o      = 0;
    int pend_acc    = 0;
    int pend_beat   = 0;
    bit prev_rd_wait = 1'b0;
    bit prev_accept  = 1'b0;
    bit prev_read    = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [15:0] prev_bcnt = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Avalon slave model, FIFO scoreboard and protocol monitor.
    always @(negedge clk) begin
        cmd_t c;
        cyc++;

        prev_o  = o_model;
        o_model = o_model + pend_acc - pend_beat;
        if (!busy) o_model = 0;

        if (wr_to_fifo) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_fifo_write", 1, 0);
            else check("fifo_data", fifo_in, exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (error) err_cnt++;
        end

        if (prev_rd_wait)
            check("cmd_held", {read, address, burstcount}, {1'b1, prev_addr, prev_bcnt});
        if (prev_accept)
            check("read_gap", read, 0);
        if (read && !prev_read)
            check("credit_rule", (int'(fifo_free) >= prev_o + int'(burstcount)), 1);

        if (read && wait_cnt > 0) begin
            waitrequest = 1'b1;
            wait_cnt--;
        end else begin
            waitrequest = 1'b0;
        end
        if (read) hold_cnt++;

        pend_beat = 0;
        if (resp_q.size() > 0 && (cyc % 5) != 3) begin
            readdatavalid = 1'b1;
            readdata      = resp_q.pop_front();
            pend_beat     = 1;
        end else begin
            readdatavalid = 1'b0;
            readdata      = 32'hDEAD_BEEF;
        end

        pend_acc    = 0;
        prev_accept = 1'b0;
        if (read && !waitrequest) begin
            if (first_hold < 0) first_hold = hold_cnt;
            hold_cnt = 0;
            for (int i = 0; i < int'(burstcount); i++)
                resp_q.push_back(mem(address + 32'(4 * i)));
            if (cmd_q.size() == 0) begin
                check("unexpected_cmd", 1, 0);
            end else begin
                c = cmd_q.pop_front();
                check("cmd_addr", address, c.addr);
                check("cmd_burstcount", burstcount, c.cnt);
                for (int i = 0; i < int'(c.cnt); i++)
                    exp_q.push_back(mem(c.addr + 32'(4 * i)));
            end
            pend_acc    = int'(burstcount);
            prev_accept = 1'b1;
            accepts++;
        end
        prev_rd_wait = read && waitrequest;
        prev_addr    = address;
        prev_bcnt    = burstcount;
        prev_read    = read;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [31:0] a, input logic [15:0] n);
        cmd_t c;
        c.addr = a;
        c.cnt  = n;
        cmd_q.push_back(c);
    endtask

    task automatic run(input logic [31:0] b, input logic [31:0] e, input bit exp_err, input int poke);
        int d0, e0, n;
        pkt_begin = b;
        pkt_end   = e;
        d0 = done_cnt;
        e0 = err_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 600) begin
            if (n == poke) start = 1'b1;
            tick();
            start = 1'b0;
            n++;
        end
        check("done_seen", done_cnt - d0, 1);
        check("error_pulse", err_cnt - e0, 64'(exp_err));
        check("cmds_left", cmd_q.size(), 0);
        check("fifo_words_left", exp_q.size(), 0);
        tick();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_read"}, read, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_wr"}, wr_to_fifo, 0);
        check({tag, "_fifo_in"}, fifo_in, 0);
        check({tag, "_address"}, address, 0);
        check({tag, "_burstcount"}, burstcount, 1);
`ifdef RD_BURST_DMA_STATS_EN
        check({tag, "_stat_words"}, stat_words, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, n;
        reset     = 1'b0;
        start     = 1'b0;
        pkt_begin = '0;
        pkt_end   = '0;
        fifo_free = 10'd512;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Four full bursts; a start pulse mid-transfer must be ignored.
        push_cmd(32'h1000, 16);
        push_cmd(32'h1040, 16);
        push_cmd(32'h1080, 16);
        push_cmd(32'h10C0, 16);
        run(32'h1000, 32'h1100, 1'b0, 10);

        // 4 KiB boundary split.
        push_cmd(32'h0FF8, 2);
        push_cmd(32'h1000, 2);
        run(32'h0FF8, 32'h1008, 1'b0, -1);

        // Short single burst; done one cycle after the last FIFO write.
        push_cmd(32'h2000, 5);
        run(32'h2000, 32'h2014, 1'b0, -1);
        check("done_after_last_wr", done_cyc - last_wr_cyc, 1);

        // Bad regions: empty, misaligned begin, reversed.
        a0 = accepts;
        run(32'h3000, 32'h3000, 1'b1, -1);
        run(32'h3002, 32'h3100, 1'b1, -1);
        run(32'h3100, 32'h3000, 1'b1, -1);
        check("bad_region_no_cmd", accepts - a0, 0);

        // waitrequest for 3 cycles on the first burst.
        wait_cnt   = 3;
        first_hold = -1;
        push_cmd(32'h4000, 16);
        push_cmd(32'h4040, 16);
        run(32'h4000, 32'h4080, 1'b0, -1);
        check("first_cmd_hold_cycles", first_hold, 4);
`ifdef RD_BURST_DMA_STATS_EN
        check("stat_stall_cycles", stat_stall_cycles, 3);
        check("stat_words", stat_words, 32);
`endif

        // Credit gating, then reset in the middle of DRAIN.
        fifo_free = 10'd8;
        a0 = accepts;
        push_cmd(32'h5000, 16);
        push_cmd(32'h5040, 16);
        push_cmd(32'h5080, 16);
        push_cmd(32'h50C0, 16);
        pkt_begin = 32'h5000;
        pkt_end   = 32'h5100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check("no_cmd_without_credit", accepts - a0, 0);
        check("busy_while_starved", busy, 1);
        fifo_free = 10'd16;
        n = 0;
        while (cmd_q.size() != 0 && n < 800) begin
            tick();
            n++;
        end
        check("credit_cmds_issued", cmd_q.size(), 0);
        repeat (3) tick();
        reset = 1'b0;
        exp_q.delete();
        d0 = done_cnt;
        tick();
        check_reset_outputs("mid_drain_reset");
        reset = 1'b1;
        repeat (30) tick();
        check("no_done_after_reset", done_cnt - d0, 0);
        check("idle_after_reset", busy, 0);
        fifo_free = 10'd512;

        // Recovery after the abandoned transfer.
        push_cmd(32'h6000, 4);
        run(32'h6000, 32'h6010, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
